// File: rtl/pulse_train_pkg.sv
// Shared state encoding for the pulse-train generator and its helpers.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_down_counter.sv
// W-bit down-counter with synchronous load; stops at zero instead of wrapping.
module pulse_down_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (en && value != '0)
            value <= value - W'(1);
    end

    assign zero = (value == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable burst generator: optional delay, then COUNT pulses of HIGH/LOW cycles,
// with one-shot / auto-repeat operation and synchronous abort.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         on,
    input  logic         repeat_en,
    input  logic         abort,
    input  logic [W-1:0] delay,
    input  logic [W-1:0] high,
    input  logic [W-1:0] low,
    input  logic [W-1:0] count,
    output logic         signal,
    output logic         busy,
    output logic         done
);

    // Phase lengths are stored as length-1; a zero length behaves as one cycle.
    function automatic logic [W-1:0] len_m1(input logic [W-1:0] v);
        return (v == '0) ? '0 : v - W'(1);
    endfunction

    state_t       state;
    logic         on_q;
    logic         zero_done;
    logic [W-1:0] h_q;
    logic [W-1:0] l_q;

    logic         phase_zero;
    logic         pulse_zero;
    logic         ph_load;
    logic [W-1:0] ph_val;
    logic         ph_en;
    logic         pc_load;
    logic [W-1:0] pc_val;
    logic         pc_en;

    logic start_ok;
    logic last_fall;
    logic restart;
    logic launch;

    assign start_ok  = (state == ST_IDLE) && on && !on_q && !abort;
    assign last_fall = (state == ST_HIGH) && phase_zero && pulse_zero;
    assign restart   = last_fall && repeat_en && on && !abort;
    assign launch    = start_ok || restart;

    always_comb begin
        ph_load = 1'b0;
        ph_val  = '0;
        if (launch) begin
            ph_load = 1'b1;
            ph_val  = (delay != '0) ? delay - W'(1) : len_m1(high);
        end else if (phase_zero) begin
            case (state)
                ST_DELAY, ST_LOW: begin
                    ph_load = 1'b1;
                    ph_val  = h_q;
                end
                ST_HIGH: begin
                    ph_load = 1'b1;
                    ph_val  = l_q;
                end
                default: ;
            endcase
        end
    end

    assign ph_en   = (state != ST_IDLE);
    assign pc_load = launch;
    assign pc_val  = (count != '0) ? count - W'(1) : '0;
    assign pc_en   = (state == ST_HIGH) && phase_zero;

    pulse_down_counter #(.W(W)) u_phase_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (ph_load),
        .en       (ph_en),
        .load_val (ph_val),
        .zero     (phase_zero)
    );

    pulse_down_counter #(.W(W)) u_pulse_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (pc_load),
        .en       (pc_en),
        .load_val (pc_val),
        .zero     (pulse_zero)
    );

    // on_q resets high so a level already asserted at reset release cannot fire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            signal    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            on_q      <= 1'b1;
            zero_done <= 1'b0;
            h_q       <= '0;
            l_q       <= '0;
        end else begin
            on_q      <= on;
            done      <= 1'b0;
            zero_done <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                signal <= 1'b0;
                busy   <= 1'b0;
            end else begin
                done <= zero_done;
                case (state)
                    ST_DELAY, ST_LOW: begin
                        if (phase_zero) begin
                            state  <= ST_HIGH;
                            signal <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (phase_zero) begin
                            signal <= 1'b0;
                            if (pulse_zero) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_LOW;
                            end
                        end
                    end
                    default: ;
                endcase

                // A launch (fresh start or repeat) overrides whatever the case chose.
                if (launch) begin
                    h_q <= len_m1(high);
                    l_q <= len_m1(low);
                    if (count == '0) begin
                        state     <= ST_IDLE;
                        signal    <= 1'b0;
                        busy      <= 1'b0;
                        zero_done <= 1'b1;
                    end else if (delay == '0) begin
                        state  <= ST_HIGH;
                        signal <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state  <= ST_DELAY;
                        signal <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
